// File: rtl/timer_arbiter.sv
// Shares one timing unit among NUM_REQ requesters, round-robin by default.
// Define TIMER_ARB_PRIORITY_EN for fixed lowest-index-wins arbitration (no rr_ptr).
module timer_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int CW      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ-1:0]    req_mode,
   input  logic [NUM_REQ*CW-1:0] req_termcount,
   input  logic [NUM_REQ-1:0]    req_cancel,
   output logic [NUM_REQ-1:0]    grant,
   output logic [NUM_REQ-1:0]    done,
   output logic                  busy,
   output logic                  tmr_trig_start,
   output logic                  tmr_trig_halt,
   output logic                  tmr_mode,
   output logic [CW-1:0]         tmr_termcount,
   input  logic                  tmr_status,
   input  logic                  tmr_int
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_RUN   = 3'd2;
   localparam logic [2:0] ST_HALT  = 3'd3;
   localparam logic [2:0] ST_DRAIN = 3'd4;

   logic [2:0]         state_q, state_d;
   logic [IW-1:0]      owner_q, owner_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               mode_q, mode_d;
   logic [CW-1:0]      tc_q, tc_d;
   logic               busy_q, start_q, halt_q;
   logic               rel;
   logic [IW-1:0]      scan_base;
   logic               pick_found;
   logic [IW-1:0]      pick_idx;

`ifdef TIMER_ARB_PRIORITY_EN
   assign scan_base = '0;
`else
   logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
   assign scan_base = rr_ptr_q;
`endif

   // Scan downward so the candidate closest to scan_base is the last (winning) assignment.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[IW'((int'(scan_base) + i) % NUM_REQ)]) begin
            pick_found = 1'b1;
            pick_idx   = IW'((int'(scan_base) + i) % NUM_REQ);
         end
      end
   end

   // NOTE: every signal written here gets a default first, so no latch can be inferred.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      grant_d = grant_q;
      done_d  = '0;
      mode_d  = mode_q;
      tc_d    = tc_q;
      rel     = 1'b0;
`ifndef TIMER_ARB_PRIORITY_EN
      rr_ptr_d = rr_ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               owner_d = pick_idx;
               mode_d  = req_mode[pick_idx];
               tc_d    = req_termcount[int'(pick_idx)*CW +: CW];
               grant_d = NUM_REQ'(1) << pick_idx;
               state_d = (tc_d == '0) ? ST_DRAIN : ST_START;
            end
         end
         ST_START: state_d = ST_RUN;
         ST_RUN: begin
            if (req_cancel[owner_q]) begin
               state_d = ST_HALT;
               if (tmr_int) done_d = grant_q;
            end else if (mode_q && !req_valid[owner_q]) begin
               state_d = ST_HALT;
            end else if (tmr_int) begin
               done_d = grant_q;
               if (!mode_q) rel = 1'b1;
            end
         end
         // The halt strobe must go out before tmr_status is trusted.
         ST_HALT: begin
            if (!halt_q && !tmr_status) rel = 1'b1;
         end
         ST_DRAIN: begin
            done_d = grant_q;
            rel    = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      if (rel) begin
         state_d = ST_IDLE;
         grant_d = '0;
`ifndef TIMER_ARB_PRIORITY_EN
         rr_ptr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
`endif
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         grant_q <= '0;
         done_q  <= '0;
         mode_q  <= 1'b0;
         tc_q    <= '0;
         busy_q  <= 1'b0;
         start_q <= 1'b0;
         halt_q  <= 1'b0;
`ifndef TIMER_ARB_PRIORITY_EN
         rr_ptr_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         mode_q  <= mode_d;
         tc_q    <= tc_d;
         busy_q  <= (state_d != ST_IDLE);
         start_q <= (state_d == ST_START);
         halt_q  <= (state_q == ST_RUN) && (state_d == ST_HALT);
`ifndef TIMER_ARB_PRIORITY_EN
         rr_ptr_q <= rr_ptr_d;
`endif
      end
   end

   assign grant          = grant_q;
   assign done           = done_q;
   assign busy           = busy_q;
   assign tmr_trig_start = start_q;
   assign tmr_trig_halt  = halt_q;
   assign tmr_mode       = mode_q;
   assign tmr_termcount  = tc_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter: directed sessions push expected events,
// a negedge monitor pops and compares them against observed DUT events.
module tb_timer_arbiter;

   localparam int NUM_REQ = 4;
   localparam int CW      = 32;

   typedef enum logic [2:0] {EV_GRANT, EV_START, EV_HALT, EV_DONE, EV_REL} ev_kind_t;
   typedef struct packed {
      ev_kind_t   kind;
      logic [3:0] bits;
      logic [1:0] aux;
   } ev_t;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_mode;
   logic [NUM_REQ*CW-1:0] req_termcount;
   logic [NUM_REQ-1:0]    req_cancel;
   logic [NUM_REQ-1:0]    grant;
   logic [NUM_REQ-1:0]    done;
   logic                  busy;
   logic                  tmr_trig_start;
   logic                  tmr_trig_halt;
   logic                  tmr_mode;
   logic [CW-1:0]         tmr_termcount;
   logic                  tmr_status = 1'b0;
   logic                  tmr_int    = 1'b0;

   int  checks = 0;
   int  errors = 0;
   ev_t exp_q[$];

   timer_arbiter #(.NUM_REQ(NUM_REQ), .CW(CW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_mode(req_mode),
      .req_termcount(req_termcount), .req_cancel(req_cancel),
      .grant(grant), .done(done), .busy(busy),
      .tmr_trig_start(tmr_trig_start), .tmr_trig_halt(tmr_trig_halt),
      .tmr_mode(tmr_mode), .tmr_termcount(tmr_termcount),
      .tmr_status(tmr_status), .tmr_int(tmr_int)
   );

   always #5 clk = ~clk;

   // Timer stub: counts down after start, halts with a two-cycle status lag.
   logic [CW-1:0] cnt = '0;
   int            halt_dly = 0;
   always @(posedge clk) begin
      #1;
      tmr_int = 1'b0;
      if (!reset) begin
         cnt = '0; tmr_status = 1'b0; halt_dly = 0;
      end else if (tmr_trig_start) begin
         cnt = tmr_termcount; tmr_status = 1'b1;
      end else if (tmr_trig_halt) begin
         halt_dly = 2;
      end else if (halt_dly > 0) begin
         halt_dly--;
         if (halt_dly == 0) begin tmr_status = 1'b0; cnt = '0; end
      end else if (tmr_status) begin
         cnt = cnt - 1'b1;
         if (cnt == '0) begin
            tmr_int = 1'b1;
            if (tmr_mode) cnt = tmr_termcount;
            else tmr_status = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic expect_ev(input ev_kind_t k, input logic [3:0] b, input logic [1:0] a);
      ev_t e;
      e.kind = k; e.bits = b; e.aux = a;
      exp_q.push_back(e);
   endtask

   // A complete one-shot session that ends on tmr_int.
   task automatic expect_oneshot(input logic [3:0] b);
      expect_ev(EV_GRANT, b, 2'b10);
      expect_ev(EV_START, b, 2'b10);
      expect_ev(EV_DONE,  b, 2'b01);
      expect_ev(EV_REL,   b, 2'b00);
   endtask

   task automatic see(input ev_kind_t k, input logic [3:0] b, input logic [1:0] a);
      ev_t got, want;
      got.kind = k; got.bits = b; got.aux = a;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event actual kind=%0d bits=%b aux=%b required none", k, b, a);
      end else begin
         want = exp_q.pop_front();
         check($sformatf("event_%s", k.name()), 32'(got), 32'(want));
      end
   endtask

   // Monitor: aux = {busy, previous tmr_int for DONE / previous tmr_status for REL}.
   logic [3:0] prev_grant  = '0;
   logic       prev_int    = 1'b0;
   logic       prev_status = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         prev_grant = '0; prev_int = 1'b0; prev_status = 1'b0;
      end else begin
         if (prev_grant == '0 && grant != '0) see(EV_GRANT, grant, {busy, 1'b0});
         if (tmr_trig_start) see(EV_START, grant, {busy, 1'b0});
         if (tmr_trig_halt)  see(EV_HALT,  grant, {busy, 1'b0});
         if (tmr_trig_start && tmr_trig_halt) check("start_halt_exclusive", 1, 0);
         if (done != '0) see(EV_DONE, done, {busy, prev_int});
         if (prev_grant != '0 && grant == '0) see(EV_REL, prev_grant, {busy, prev_status});
         prev_grant  = grant;
         prev_int    = tmr_int;
         prev_status = tmr_status;
      end
   end

   task automatic set_req(input int idx, input logic mode, input logic [CW-1:0] tc);
      req_mode[idx] = mode;
      req_termcount[idx*CW +: CW] = tc;
   endtask

   task automatic wait_grant(input int idx, input string name);
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (grant[idx]) break;
      end
      check(name, 32'(grant[idx]), 1);
   endtask

   task automatic wait_idle(input string name);
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check(name, 32'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int rr_order[5];
      logic was;
`ifdef TIMER_ARB_PRIORITY_EN
      rr_order = '{0, 0, 0, 0, 0};
`else
      rr_order = '{0, 1, 2, 3, 0};
`endif
      reset = 1'b0; req_valid = '0; req_mode = '0; req_termcount = '0; req_cancel = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({grant, done, busy, tmr_trig_start, tmr_trig_halt, tmr_mode}), 0);
      check("reset_termcount", tmr_termcount, 0);
      reset = 1'b1;
      @(negedge clk);

      // Requester 0 one-shot, termcount 5.
      expect_oneshot(4'b0001);
      set_req(0, 1'b0, 5);
      req_valid[0] = 1'b1;
      wait_grant(0, "t1_grant");
      req_valid[0] = 1'b0;
      check("t1_termcount", tmr_termcount, 5);
      check("t1_busy", 32'(busy), 1);
      wait_idle("t1_idle");
      check("t1_grant_clear", 32'(grant), 0);

      // Requester 3 with termcount 0: drain, no timer start; rr_ptr wraps to 0.
      expect_ev(EV_GRANT, 4'b1000, 2'b10);
      expect_ev(EV_DONE,  4'b1000, 2'b00);
      expect_ev(EV_REL,   4'b1000, 2'b00);
      set_req(3, 1'b0, 0);
      req_valid[3] = 1'b1;
      wait_grant(3, "t5_grant");
      req_valid[3] = 1'b0;
      wait_idle("t5_idle");

      // All four requesting one-shot termcount 3.
      for (int i = 0; i < 4; i++) set_req(i, 1'b0, 3);
      for (int i = 0; i < 5; i++) expect_oneshot(4'(1 << rr_order[i]));
      req_valid = 4'b1111;
      n = 0; was = 1'b0;
      for (int c = 0; c < 600 && n < 5; c++) begin
         @(negedge clk);
         if (grant != '0 && !was) n++;
         was = (grant != '0);
      end
      req_valid = '0;
      check("t2_grant_count", n, 5);
      wait_idle("t2_idle");

      // Requester 2 periodic, termcount 4: three done pulses then drop valid.
      expect_ev(EV_GRANT, 4'b0100, 2'b10);
      expect_ev(EV_START, 4'b0100, 2'b10);
      for (int i = 0; i < 3; i++) expect_ev(EV_DONE, 4'b0100, 2'b11);
      expect_ev(EV_HALT, 4'b0100, 2'b10);
      expect_ev(EV_REL,  4'b0100, 2'b00);
      set_req(2, 1'b1, 4);
      req_valid[2] = 1'b1;
      wait_grant(2, "t3_grant");
      check("t3_mode", 32'(tmr_mode), 1);
      check("t3_termcount", tmr_termcount, 4);
      n = 0;
      for (int c = 0; c < 200 && n < 3; c++) begin
         @(negedge clk);
         if (done[2]) n++;
      end
      req_valid[2] = 1'b0;
      check("t3_done_count", n, 3);
      wait_idle("t3_idle");
      check("t3_status_at_release", 32'(tmr_status), 0);

      // Requester 1 one-shot 100, cancelled; non-owner cancel ignored; 3 goes next.
      expect_ev(EV_GRANT, 4'b0010, 2'b10);
      expect_ev(EV_START, 4'b0010, 2'b10);
      expect_ev(EV_HALT,  4'b0010, 2'b10);
      expect_ev(EV_REL,   4'b0010, 2'b00);
      expect_oneshot(4'b1000);
      set_req(1, 1'b0, 100);
      req_valid[1] = 1'b1;
      wait_grant(1, "t4_grant");
      req_valid[1] = 1'b0;
      repeat (5) @(negedge clk);
      set_req(3, 1'b0, 2);
      req_valid[3] = 1'b1;
      req_cancel[3] = 1'b1;
      @(negedge clk);
      req_cancel[3] = 1'b0;
      repeat (3) @(negedge clk);
      check("t4_nonowner_cancel", 32'({busy, grant}), 32'(5'b1_0010));
      req_cancel[1] = 1'b1;
      @(negedge clk);
      req_cancel[1] = 1'b0;
      wait_grant(3, "t4_next_grant");
      req_valid[3] = 1'b0;
      wait_idle("t4_idle");

      // Reset during RUN, after rr_ptr has moved off 0.
      expect_oneshot(4'b0010);
      set_req(1, 1'b0, 2);
      req_valid[1] = 1'b1;
      wait_grant(1, "t6_pre_grant");
      req_valid[1] = 1'b0;
      wait_idle("t6_pre_idle");
      expect_ev(EV_GRANT, 4'b0100, 2'b10);
      expect_ev(EV_START, 4'b0100, 2'b10);
      set_req(2, 1'b0, 50);
      req_valid[2] = 1'b1;
      wait_grant(2, "t6_grant");
      req_valid[2] = 1'b0;
      repeat (6) @(negedge clk);
      check("t6_running", 32'(busy), 1);
      reset = 1'b0;
      @(negedge clk);
      check("t6_reset_outputs", 32'({grant, done, busy, tmr_trig_start, tmr_trig_halt, tmr_mode}), 0);
      check("t6_reset_termcount", tmr_termcount, 0);
      reset = 1'b1;
      expect_oneshot(4'b0010);
      set_req(1, 1'b0, 2);
      set_req(2, 1'b0, 2);
      req_valid = 4'b0110;
      wait_grant(1, "t6_post_grant");
      req_valid = '0;
      wait_idle("t6_post_idle");

      repeat (5) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
